// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory target for the pipeline MEM stage. One request is
//   accepted at a time through a valid/ready handshake. Its response arrives
//   a fixed LATENCY cycles after the accept cycle. While a request is in flight
//   the block raises stall so the pipeline holds its front stages.
// Ports
//   clk        : clock, rising-edge state updates
//   reset      : synchronous active-high reset
//   req_valid  : request present (held stable by the pipeline while stalled)
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   req_ready  : high in IDLE only
//   rsp_valid  : one-cycle completion pulse
//   rsp_rdata  : load data (0 for stores and errors), held until next response
//   rsp_err    : misaligned or out-of-range address, held like rsp_rdata
//   stall      : pipeline hold request
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept_s;
    logic             enter_resp_s;
    logic             op_write_s;
    logic [31:0]      op_addr_s;
    logic [31:0]      op_wdata_s;
    logic [31:0]      offset_s;
    logic             op_err_s;
    logic [IDX_W-1:0] op_idx_s;
    logic             mem_we_s;

    assign accept_s = req_valid & (state_q == S_IDLE);

    // Operation being completed: with LATENCY=1 the response is entered
    // straight from IDLE, before the captured registers hold the request.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_write_s = req_write;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
        end else begin
            op_write_s = wr_q;
            op_addr_s  = addr_q;
            op_wdata_s = wdata_q;
        end
    end

    // Address decode and error classification of the completing operation.
    always_comb begin
        offset_s = op_addr_s - BASE_ADDR;
        op_idx_s = offset_s[IDX_W+1:2];
        op_err_s = (op_addr_s[1:0] != 2'b00)
                 | (op_addr_s < BASE_ADDR)
                 | ((offset_s >> 2) >= 32'(DEPTH_WORDS));
    end

    // Next-state, counter, capture and response-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        enter_resp_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d      = S_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // Saturating decrement: the counter is only reloaded in IDLE.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                if (cnt_q == 4'd1) begin
                    state_d      = S_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load data is sampled on the same edge as the store commit, so a
        // load sees the array contents from before that edge.
        if (enter_resp_s) begin
            err_d = op_err_s;
            if (op_err_s || op_write_s) begin
                rdata_d = 32'h0000_0000;
            end else begin
                rdata_d = mem_q[op_idx_s];
            end
        end else begin
            err_d   = err_q;
            rdata_d = rdata_q;
        end
    end

    // Reset on the commit edge wins, so the store is dropped.
    assign mem_we_s = enter_resp_s & op_write_s & ~op_err_s & ~reset;

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array, deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[op_idx_s] <= op_wdata_s;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign stall     = ((state_q == S_IDLE) & req_valid) | (state_q == S_WAIT);

endmodule
